// File: rtl/rf_exec_sequencer_if.sv
// Instruction handshake and register-file control bundle for
// the execute/writeback sequencer.
interface rf_exec_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [15:0]       imm;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic [DATA_W-1:0] result;
    logic              done;
    logic              busy;

    modport master (
        output in_valid, op, rd, rs, rt, imm,
        output rf_rdata1, rf_rdata2,
        input  in_ready, rf_we, rf_raddr1, rf_raddr2,
        input  rf_waddr, rf_wdata, result, done, busy
    );

    modport slave (
        input  in_valid, op, rd, rs, rt, imm,
        input  rf_rdata1, rf_rdata2,
        output in_ready, rf_we, rf_raddr1, rf_raddr2,
        output rf_waddr, rf_wdata, result, done, busy
    );
endinterface

// File: rtl/rf_exec_sequencer.sv
// Four-cycle IDLE/READ/EXEC/WB sequencer driving a 32x32 register
// file: reads two operands, computes one ALU result, writes it back.
module rf_exec_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_exec_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_SLL  = 3'd6;
    localparam logic [2:0] OP_ADDI = 3'd7;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [15:0]       imm_q, imm_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] imm_sx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            imm_q    <= imm_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    assign imm_sx = {{(DATA_W-16){imm_q[15]}}, imm_q};

    always_comb begin
        alu = '0;
        unique case (op_q)
            OP_ADD:  alu = opa_q + opb_q;
            OP_SUB:  alu = opa_q - opb_q;
            OP_AND:  alu = opa_q & opb_q;
            OP_OR:   alu = opa_q | opb_q;
            OP_XOR:  alu = opa_q ^ opb_q;
            OP_SLT:  alu = {{(DATA_W-1){1'b0}},
                            $signed(opa_q) < $signed(opb_q)};
            OP_SLL:  alu = opa_q << opb_q[4:0];
            OP_ADDI: alu = opa_q + imm_sx;
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        imm_d    = imm_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op;
                    rd_d    = bus.rd;
                    rs_d    = bus.rs;
                    rt_d    = bus.rt;
                    imm_d   = bus.imm;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                opa_d   = bus.rf_rdata1;
                opb_d   = bus.rf_rdata2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu;
                state_d  = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rs_q/rt_q only change on accept, so the read ports hold
    // the last READ addresses while idle or writing back.
    assign bus.rf_raddr1 = rs_q;
    assign bus.rf_raddr2 = rt_q;
    assign bus.rf_waddr  = rd_q;
    assign bus.rf_wdata  = result_q;
    assign bus.result    = result_q;
    assign bus.rf_we     = (state_q == S_WB) && (rd_q != '0);
    assign bus.done      = (state_q == S_WB);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.in_ready  = (state_q == S_IDLE);
endmodule

// File: tb/tb_rf_exec_sequencer.sv
// Directed bench for rf_exec_sequencer with a behavioural 32x32
// register file (combinational read, synchronous write).
module tb_rf_exec_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    rf_exec_sequencer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_exec_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] regs [32];
    bit          r8_written = 1'b0;

    assign bus.rf_rdata1 = regs[bus.rf_raddr1];
    assign bus.rf_rdata2 = regs[bus.rf_raddr2];

    always @(posedge clk) begin
        if (bus.rf_we) regs[bus.rf_waddr] <= bus.rf_wdata;
        if (bus.rf_we && bus.rf_waddr == 5'd8) r8_written = 1'b1;
    end

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t tv [18];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_instr(input vec_t v, output int lat,
                             output int low, output bit we);
        lat = 0;
        low = 0;
        we  = 1'b0;
        @(negedge clk);
        bus.op       = v.op;
        bus.rd       = v.rd;
        bus.rs       = v.rs;
        bus.rt       = v.rt;
        bus.imm      = v.imm;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (!bus.in_ready) low++;
            if (bus.rf_we) we = 1'b1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, low, acc, dn;
        bit we;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.rd       = '0;
        bus.rs       = '0;
        bus.rt       = '0;
        bus.imm      = '0;

        tv[0]  = '{3'd7, 5'd1,  5'd0, 5'd0, 16'h0005, 32'h0000_0005};
        tv[1]  = '{3'd7, 5'd2,  5'd0, 5'd0, 16'hFFFF, 32'hFFFF_FFFF};
        tv[2]  = '{3'd0, 5'd3,  5'd1, 5'd2, 16'h0000, 32'h0000_0004};
        tv[3]  = '{3'd1, 5'd4,  5'd0, 5'd1, 16'h0000, 32'hFFFF_FFFB};
        tv[4]  = '{3'd5, 5'd5,  5'd2, 5'd1, 16'h0000, 32'h0000_0001};
        tv[5]  = '{3'd6, 5'd6,  5'd1, 5'd1, 16'h0000, 32'h0000_00A0};
        tv[6]  = '{3'd4, 5'd7,  5'd1, 5'd2, 16'h0000, 32'hFFFF_FFFA};
        tv[7]  = '{3'd2, 5'd10, 5'd2, 5'd1, 16'h0000, 32'h0000_0005};
        tv[8]  = '{3'd3, 5'd11, 5'd1, 5'd6, 16'h0000, 32'h0000_00A5};
        tv[9]  = '{3'd5, 5'd12, 5'd1, 5'd2, 16'h0000, 32'h0000_0000};
        tv[10] = '{3'd0, 5'd0,  5'd1, 5'd1, 16'h0000, 32'h0000_000A};
        tv[11] = '{3'd7, 5'd13, 5'd1, 5'd7, 16'h8000, 32'hFFFF_8005};
        tv[12] = '{3'd6, 5'd14, 5'd1, 5'd6, 16'h0000, 32'h0000_0005};
        tv[13] = '{3'd7, 5'd9,  5'd0, 5'd0, 16'h0001, 32'h0000_0001};
        tv[14] = '{3'd0, 5'd9,  5'd9, 5'd9, 16'h0000, 32'h0000_0002};
        tv[15] = '{3'd0, 5'd9,  5'd9, 5'd9, 16'h0000, 32'h0000_0004};
        tv[16] = '{3'd0, 5'd9,  5'd9, 5'd9, 16'h0000, 32'h0000_0008};
        tv[17] = '{3'd0, 5'd9,  5'd9, 5'd9, 16'h0000, 32'h0000_0010};

        // reset values
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_we",       32'(bus.rf_we),    32'd0);
        chk("rst_raddr1",   32'(bus.rf_raddr1), 32'd0);
        chk("rst_raddr2",   32'(bus.rf_raddr2), 32'd0);
        chk("rst_waddr",    32'(bus.rf_waddr), 32'd0);
        chk("rst_wdata",    bus.rf_wdata,      32'd0);
        chk("rst_result",   bus.result,        32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            run_instr(tv[i], lat, low, we);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d_ready_low", i), 32'(low), 32'd3);
            chk($sformatf("v%0d_we", i), 32'(we),
                32'(tv[i].rd != 5'd0));
            chk($sformatf("v%0d_result", i), bus.result, tv[i].exp);
            chk($sformatf("v%0d_reg", i), regs[tv[i].rd],
                (tv[i].rd == 5'd0) ? 32'd0 : tv[i].exp);
            chk($sformatf("v%0d_raddr1", i), 32'(bus.rf_raddr1),
                32'(tv[i].rs));
            chk($sformatf("v%0d_raddr2", i), 32'(bus.rf_raddr2),
                32'(tv[i].rt));
            chk($sformatf("v%0d_ready_back", i),
                32'(bus.in_ready), 32'd1);
        end

        // in_valid held through busy; fields churn while busy
        acc = 0;
        dn  = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            bus.op       = 3'd7;
            bus.rs       = 5'd0;
            bus.rt       = 5'd0;
            bus.in_valid = 1'b1;
            if (i >= 2 && i <= 4) begin
                bus.rd  = 5'd16;
                bus.imm = 16'd99;
            end else begin
                bus.rd  = 5'd15;
                bus.imm = 16'd3;
            end
            if (bus.in_ready) acc++;
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_accepts", 32'(acc), 32'd2);
        chk("hold_dones",   32'(dn),  32'd2);
        chk("hold_r15",     regs[15], 32'd3);
        chk("hold_r16",     regs[16], 32'd0);

        // reset during EXEC of ADDI r8,r0,7
        @(negedge clk);
        bus.op       = 3'd7;
        bus.rd       = 5'd8;
        bus.rs       = 5'd0;
        bus.rt       = 5'd0;
        bus.imm      = 16'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_busy",     32'(bus.busy),     32'd0);
        chk("mid_done",     32'(bus.done),     32'd0);
        chk("mid_we",       32'(bus.rf_we),    32'd0);
        chk("mid_result",   bus.result,        32'd0);
        chk("mid_waddr",    32'(bus.rf_waddr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_r8",       regs[8],           32'd0);
        chk("mid_r8_we",    32'(r8_written),   32'd0);
        chk("mid_ready_up", 32'(bus.in_ready), 32'd1);
        chk("mid_r0",       regs[0],           32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rf_exec_sequencer.md
Name: rf_exec_sequencer

Overview:
- Multi-cycle execute/writeback sequencer that sits directly in front of the 32x32 register file.
- Accepts one register-register or register-immediate instruction through a valid/ready handshake.
- Reads two operands through the regfile's combinational read ports, computes a 32-bit result, and writes it back through the regfile write port.
- Owns every regfile control pin: we, raddr1, raddr2, waddr, wdata.

Parameters:
- DATA_W, 32, datapath and regfile word width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present on op/rd/rs/rt/imm.
- in_ready  out  1  sequencer can accept an instruction this cycle.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 ADDI.
- rd  in  ADDR_W  destination register.
- rs  in  ADDR_W  source register 1.
- rt  in  ADDR_W  source register 2 (ignored for ADDI).
- imm  in  16  immediate, sign-extended, used only by ADDI.
- rf_we  out  1  regfile write enable.
- rf_raddr1  out  ADDR_W  regfile read address 1.
- rf_raddr2  out  ADDR_W  regfile read address 2.
- rf_waddr  out  ADDR_W  regfile write address.
- rf_wdata  out  DATA_W  regfile write data.
- rf_rdata1  in  DATA_W  regfile read data 1 (combinational from rf_raddr1).
- rf_rdata2  in  DATA_W  regfile read data 2 (combinational from rf_raddr2).
- result  out  DATA_W  last computed result, held until next EXEC.
- done  out  1  one-cycle pulse during WB.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Outputs: in_ready=1, rf_we=0, done=0, busy=0.
  - rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, result and all latched operands/instruction fields = 0.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. No other transitions except reset.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: latch op, rd, rs, rt, imm; go to READ.
  - in_valid=0: stay in IDLE.
- READ:
  - in_ready=0.
  - rf_raddr1=rs_q, rf_raddr2=rt_q (driven from latched fields for the whole cycle).
  - At the end of the cycle, capture rf_rdata1/rf_rdata2 into opa/opb; go to EXEC.
- EXEC: compute into the result register at the end of the cycle; go to WB.
  - ADD/SUB/ADDI: modulo 2^32, wrap-around, no overflow flag.
  - AND/OR/XOR: bitwise.
  - SLT: 1 if opa < opb signed, else 0.
  - SLL: opa << opb[4:0]; upper bits of opb are ignored.
  - ADDI: opa + {{16{imm[15]}}, imm}.
- WB:
  - rf_waddr=rd_q, rf_wdata=result, done=1.
  - rf_we=1 only if rd_q != 0; writes to r0 are suppressed, but done still pulses.
  - Next edge: go to IDLE.
- Read address hold: rf_raddr1/2 keep their last READ values outside READ and are never X after reset.
- Latency and throughput:
  - Handshake at edge k: READ in cycle k+1, EXEC in k+2, WB/done in k+3, in_ready=1 again in k+4.
  - Throughput is one instruction per 4 cycles.
- Hazards: back-to-back dependent instructions need no forwarding. The WB write commits at the WB->IDLE edge, before the next READ cycle.
- in_valid while busy: ignored. Fields change freely and have no effect until IDLE.
- Reset mid-instruction:
  - Any state goes to IDLE immediately; rf_we and done drop asynchronously.
  - The in-flight instruction is discarded with no partial write.
- Result register: holds its value across IDLE; updated only in EXEC.

Test Plan:
- Bench instantiates this block with a behavioural 32x32 regfile (combinational read, synchronous write, all zero at start).
- ADDI r1,r0,imm=5 then ADDI r2,r0,imm=0xFFFF -> r1=0x00000005, r2=0xFFFFFFFF; done exactly 3 cycles after each accept; in_ready low for 3 cycles.
- ADD r3,r1,r2 and SUB r4,r0,r1 -> r3=0x00000004 (wrap), r4=0xFFFFFFFB.
- SLT r5,r2,r1 -> r5=1 (signed -1<5); SLL r6,r1,r1 -> r6=0x000000A0; XOR r7,r1,r2 -> r7=0xFFFFFFFA.
- ADD r0,r1,r1 -> done pulses, rf_we stays 0 throughout, r0 remains 0. Hold in_valid=1 during busy -> exactly one instruction accepted per IDLE cycle.
- Assert rst=0 during the EXEC of ADDI r8,r0,7 -> rf_we never asserts, r8 stays 0, outputs at reset values, in_ready=1 on release.
- Dependent chain (ADDI r9,r0,1; ADD r9,r9,r9 x4) -> r9=0x10, no stale operand reads.
